// File: rtl/icache_block_param_pkg.sv
// Shared definitions for the instruction cache block: miss FSM states and
// address-field width helpers.
package icache_block_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic int tag_width(input int addr_w, input int sets, input int off_w);
        return addr_w - off_w - $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_block_param_plru_tree.sv
// Per-set tree pseudo-LRU: WAYS-1 node bits per set, heap ordered (root = node 1).
// A node bit of 1 steers the victim search to the upper half of its subtree.
module icache_block_param_plru_tree #(
    parameter int WAYS = 4,
    parameter int SETS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    upd_en,
    input  logic [$clog2(SETS)-1:0] set_idx,
    input  logic [$clog2(WAYS)-1:0] upd_way,
    output logic [$clog2(WAYS)-1:0] victim
);

    localparam int WAY_W = $clog2(WAYS);

    logic [SETS-1:0][WAYS-2:0] bits_q;
    logic [WAYS-2:0]           cur_bits;
    logic [WAYS-2:0]           nxt_bits;

    always_comb begin
        int node;
        cur_bits = bits_q[set_idx];
        nxt_bits = cur_bits;
        victim   = '0;
        node     = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            victim[WAY_W-1-lvl] = cur_bits[node-1];
            node = 2 * node + int'(cur_bits[node-1]);
        end
        // Walk the used way's path, pointing every node at the other half.
        node = 1;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            nxt_bits[node-1] = ~upd_way[WAY_W-1-lvl];
            node = 2 * node + int'(upd_way[WAY_W-1-lvl]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_q <= '0;
        end else if (upd_en) begin
            bits_q[set_idx] <= nxt_bits;
        end
    end

endmodule

// File: rtl/icache_block_param.sv
// N-way set-associative read-only instruction cache: 1-cycle hits, miss fill over
// the common bus through a request/grant/fill FSM, snoop invalidation in any state.
module icache_block_param
    import icache_block_param_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAYS   = 4,
    parameter int SETS   = 64,
    parameter int OFF_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pr_rd,
    input  logic [ADDR_W-1:0]       pr_addr,
    output logic [DATA_W-1:0]       pr_data,
    output logic                    pr_data_vld,
    output logic                    cpu_stall,
    output logic                    com_bus_req,
    input  logic                    com_bus_gnt,
    output logic [ADDR_W-1:0]       com_addr,
    output logic                    com_addr_vld,
    input  logic [DATA_W-1:0]       com_data,
    input  logic                    com_data_vld,
    input  logic                    inv_vld,
    input  logic [ADDR_W-1:0]       inv_addr,
    output logic [$clog2(WAYS)-1:0] blk_accessed
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = tag_width(ADDR_W, SETS, OFF_W);

    logic [TAG_W-1:0]          tag_mem  [SETS*WAYS];
    logic [DATA_W-1:0]         data_mem [SETS*WAYS];
    logic [SETS-1:0][WAYS-1:0] valid_q;

    state_e           state_q;
    logic [WAY_W-1:0] victim_q;

    logic [TAG_W-1:0] cur_tag, inv_tag;
    logic [IDX_W-1:0] cur_idx, inv_idx;
    logic [WAYS-1:0]  hit_vec, inv_vec;
    logic [WAY_W-1:0] hit_way, free_way, plru_victim;
    logic             hit, has_free;
    logic             hit_rd, fill_we, inv_on_fill, plru_upd;
    logic [WAY_W-1:0] plru_way;
    logic             unused_ok;

    assign cur_tag   = pr_addr[ADDR_W-1 -: TAG_W];
    assign cur_idx   = pr_addr[OFF_W +: IDX_W];
    assign inv_tag   = inv_addr[ADDR_W-1 -: TAG_W];
    assign inv_idx   = inv_addr[OFF_W +: IDX_W];
    assign unused_ok = ^{pr_addr[OFF_W-1:0], inv_addr[OFF_W-1:0]};

    always_comb begin
        hit_vec = '0;
        inv_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[cur_idx][w] && (tag_mem[{cur_idx, WAY_W'(w)}] == cur_tag);
            inv_vec[w] = valid_q[inv_idx][w] && (tag_mem[{inv_idx, WAY_W'(w)}] == inv_tag);
        end
    end

    always_comb begin
        hit_way  = '0;
        free_way = '0;
        has_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[cur_idx][w]) begin
                free_way = WAY_W'(w);
                has_free = 1'b1;
            end
        end
    end

    assign hit         = |hit_vec;
    assign hit_rd      = (state_q == ST_IDLE) && pr_rd && hit;
    assign fill_we     = (state_q == ST_FILL) && com_data_vld;
    assign inv_on_fill = inv_vld && (inv_tag == cur_tag) && (inv_idx == cur_idx);
    assign plru_upd    = hit_rd || fill_we;
    assign plru_way    = fill_we ? victim_q : hit_way;

    icache_block_param_plru_tree #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk     (clk),
        .rst     (rst),
        .upd_en  (plru_upd),
        .set_idx (cur_idx),
        .upd_way (plru_way),
        .victim  (plru_victim)
    );

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[{cur_idx, victim_q}]  <= cur_tag;
            data_mem[{cur_idx, victim_q}] <= com_data;
        end
    end

    // A snoop hitting the line being filled wins: the line is left invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (fill_we) valid_q[cur_idx][victim_q] <= !inv_on_fill;
            if (inv_vld) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (inv_vec[w] && !(fill_we && (inv_idx == cur_idx) && (victim_q == WAY_W'(w))))
                        valid_q[inv_idx][w] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            victim_q     <= '0;
            pr_data      <= '0;
            pr_data_vld  <= 1'b0;
            cpu_stall    <= 1'b0;
            com_bus_req  <= 1'b0;
            com_addr     <= '0;
            com_addr_vld <= 1'b0;
            blk_accessed <= '0;
        end else begin
            pr_data_vld <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pr_rd) begin
                        if (hit) begin
                            pr_data      <= data_mem[{cur_idx, hit_way}];
                            pr_data_vld  <= 1'b1;
                            blk_accessed <= hit_way;
                        end else begin
                            victim_q    <= has_free ? free_way : plru_victim;
                            cpu_stall   <= 1'b1;
                            com_bus_req <= 1'b1;
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (com_bus_gnt) begin
                        com_addr     <= {pr_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        com_addr_vld <= 1'b1;
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (com_data_vld) begin
                        pr_data      <= com_data;
                        pr_data_vld  <= 1'b1;
                        cpu_stall    <= 1'b0;
                        blk_accessed <= victim_q;
                        com_bus_req  <= 1'b0;
                        com_addr     <= '0;
                        com_addr_vld <= 1'b0;
                        state_q      <= ST_RESP;
                    end else if (!com_bus_gnt) begin
                        // Grant lost before data: re-arbitrate, victim stays latched.
                        com_addr     <= '0;
                        com_addr_vld <= 1'b0;
                        state_q      <= ST_REQ;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_block_param.sv
// Bench for icache_block_param: directed scenarios plus a randomized phase, all
// checked against a line-level cache model with an interval-walk pseudo-LRU.
module tb_icache_block_param;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WAYS   = 4;
    localparam int SETS   = 64;
    localparam int OFF_W  = 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W  = $clog2(WAYS);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pr_rd = 1'b0;
    logic [ADDR_W-1:0] pr_addr = '0;
    logic [DATA_W-1:0] pr_data;
    logic              pr_data_vld;
    logic              cpu_stall;
    logic              com_bus_req;
    logic              com_bus_gnt = 1'b0;
    logic [ADDR_W-1:0] com_addr;
    logic              com_addr_vld;
    logic [DATA_W-1:0] com_data = '0;
    logic              com_data_vld = 1'b0;
    logic              inv_vld = 1'b0;
    logic [ADDR_W-1:0] inv_addr = '0;
    logic [WAY_W-1:0]  blk_accessed;

    int n_chk = 0;
    int n_err = 0;

    icache_block_param #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .WAYS (WAYS), .SETS (SETS), .OFF_W (OFF_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pr_rd        (pr_rd),
        .pr_addr      (pr_addr),
        .pr_data      (pr_data),
        .pr_data_vld  (pr_data_vld),
        .cpu_stall    (cpu_stall),
        .com_bus_req  (com_bus_req),
        .com_bus_gnt  (com_bus_gnt),
        .com_addr     (com_addr),
        .com_addr_vld (com_addr_vld),
        .com_data     (com_data),
        .com_data_vld (com_data_vld),
        .inv_vld      (inv_vld),
        .inv_addr     (inv_addr),
        .blk_accessed (blk_accessed)
    );

    always #5 clk = ~clk;

    // Reference model: lines per set; m_up[s][mid] says the subtree split at
    // way 'mid' should next evict from its upper half.
    bit               m_valid [SETS][WAYS];
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    logic [31:0]      m_data  [SETS][WAYS];
    bit               m_up    [SETS][WAYS];

    function automatic int f_set(input logic [31:0] a);
        return int'((a >> OFF_W) & (SETS - 1));
    endfunction

    function automatic logic [TAG_W-1:0] f_tag(input logic [31:0] a);
        return a[31:OFF_W+IDX_W];
    endfunction

    function automatic int m_lookup(input logic [31:0] a);
        int s = f_set(a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == f_tag(a)) return w;
        return -1;
    endfunction

    function automatic void m_touch(input int s, input int w);
        int lo = 0, hi = WAYS, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            m_up[s][mid] = (w < mid);
            if (w < mid) hi = mid; else lo = mid;
        end
    endfunction

    function automatic int m_victim(input int s);
        int lo = 0, hi = WAYS, mid;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (m_up[s][mid]) lo = mid; else hi = mid;
        end
        return lo;
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_up[s][w]    = 1'b0;
            end
    endfunction

    function automatic void m_inv(input logic [31:0] a);
        int w = m_lookup(a);
        if (w >= 0) m_valid[f_set(a)][w] = 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pr_rd = 1'b0; com_bus_gnt = 1'b0; com_data_vld = 1'b0; inv_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        m_clear();
    endtask

    task automatic do_idle_inv(input logic [31:0] a);
        inv_vld = 1'b1;
        inv_addr = a;
        tick();
        inv_vld = 1'b0;
        m_inv(a);
    endtask

    task automatic do_read(input logic [31:0] a, input int gdly, input int ddly,
                           input logic [31:0] fdata, input bit inv_same, input bit drop_gnt);
        int s = f_set(a);
        int w = m_lookup(a);
        int v;
        pr_rd = 1'b1;
        pr_addr = a;
        if (w >= 0) begin
            if (inv_same) begin inv_vld = 1'b1; inv_addr = a; end
            tick();
            inv_vld = 1'b0;
            chk("hit_vld", 64'(pr_data_vld), 64'(1));
            chk("hit_data", 64'(pr_data), 64'(m_data[s][w]));
            chk("hit_way", 64'(blk_accessed), 64'(w));
            chk("hit_stall", 64'(cpu_stall), 64'(0));
            m_touch(s, w);
            if (inv_same) m_valid[s][w] = 1'b0;
            pr_rd = 1'b0;
        end else begin
            v = m_victim(s);
            tick();
            chk("miss_stall", 64'(cpu_stall), 64'(1));
            chk("miss_req", 64'(com_bus_req), 64'(1));
            chk("miss_avld", 64'(com_addr_vld), 64'(0));
            for (int i = 0; i < gdly; i++) begin
                tick();
                chk("wait_req", 64'(com_bus_req), 64'(1));
                chk("wait_avld", 64'(com_addr_vld), 64'(0));
                chk("wait_stall", 64'(cpu_stall), 64'(1));
            end
            com_bus_gnt = 1'b1;
            tick();
            chk("fill_avld", 64'(com_addr_vld), 64'(1));
            chk("fill_addr", 64'(com_addr), 64'({a[31:OFF_W], 2'b00}));
            if (drop_gnt) begin
                com_bus_gnt = 1'b0;
                tick();
                chk("drop_avld", 64'(com_addr_vld), 64'(0));
                chk("drop_addr", 64'(com_addr), 64'(0));
                chk("drop_req", 64'(com_bus_req), 64'(1));
                com_bus_gnt = 1'b1;
                tick();
                chk("regnt_avld", 64'(com_addr_vld), 64'(1));
            end
            for (int i = 0; i < ddly; i++) begin
                tick();
                chk("hold_avld", 64'(com_addr_vld), 64'(1));
                chk("hold_stall", 64'(cpu_stall), 64'(1));
            end
            com_data_vld = 1'b1;
            com_data = fdata;
            if (inv_same) begin inv_vld = 1'b1; inv_addr = a; end
            tick();
            com_data_vld = 1'b0;
            com_bus_gnt = 1'b0;
            inv_vld = 1'b0;
            chk("resp_vld", 64'(pr_data_vld), 64'(1));
            chk("resp_data", 64'(pr_data), 64'(fdata));
            chk("resp_way", 64'(blk_accessed), 64'(v));
            chk("resp_stall", 64'(cpu_stall), 64'(0));
            chk("resp_req", 64'(com_bus_req), 64'(0));
            chk("resp_avld", 64'(com_addr_vld), 64'(0));
            pr_rd = 1'b0;
            m_valid[s][v] = !inv_same;
            m_tag[s][v]   = f_tag(a);
            m_data[s][v]  = fdata;
            m_touch(s, v);
            tick();
        end
        if (cpu_stall !== 1'b0) do_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        m_clear();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_data", 64'(pr_data), 64'(0));
        chk("rst_vld", 64'(pr_data_vld), 64'(0));
        chk("rst_stall", 64'(cpu_stall), 64'(0));
        chk("rst_req", 64'(com_bus_req), 64'(0));
        chk("rst_addr", 64'(com_addr), 64'(0));
        chk("rst_avld", 64'(com_addr_vld), 64'(0));
        chk("rst_blk", 64'(blk_accessed), 64'(0));

        // Cold miss with data two cycles after grant, then a 1-cycle hit.
        do_read(32'h0000_1000, 0, 2, 32'hCAFE_F00D, 1'b0, 1'b0);
        do_read(32'h0000_1000, 0, 0, 32'h0, 1'b0, 1'b0);
        chk("t1_hit_data", 64'(pr_data), 64'(32'hCAFE_F00D));

        // Fill set 0, touch ways 0 and 2, next miss evicts way 1.
        do_read(32'h0000_2000, 1, 0, 32'h2222_0000, 1'b0, 1'b0);
        do_read(32'h0000_3000, 0, 1, 32'h3333_0000, 1'b0, 1'b0);
        do_read(32'h0000_4000, 2, 0, 32'h4444_0000, 1'b0, 1'b0);
        do_read(32'h0000_1000, 0, 0, 32'h0, 1'b0, 1'b0);
        do_read(32'h0000_3000, 0, 0, 32'h0, 1'b0, 1'b0);
        do_read(32'h0000_5000, 0, 0, 32'h5555_0000, 1'b0, 1'b0);
        chk("t2_victim_way", 64'(blk_accessed), 64'(1));

        // Grant withheld for 10 cycles.
        do_read(32'h0000_6004, 10, 0, 32'h6666_0000, 1'b0, 1'b0);

        // Snoop invalidate of a cached line, then it misses.
        do_idle_inv(32'h0000_1000);
        do_read(32'h0000_1000, 0, 0, 32'h1111_1111, 1'b0, 1'b0);

        // Snoop coinciding with fill data: data returned, line stays invalid.
        do_read(32'h0000_7008, 0, 1, 32'h7777_0000, 1'b1, 1'b0);
        do_read(32'h0000_7008, 0, 0, 32'h7777_1111, 1'b0, 1'b0);

        // Snoop coinciding with a hit: pre-invalidate data, then a miss.
        do_read(32'h0000_7008, 0, 0, 32'h0, 1'b1, 1'b0);
        do_read(32'h0000_7008, 1, 0, 32'h7777_2222, 1'b0, 1'b1);

        // Asynchronous reset during FILL.
        pr_rd = 1'b1;
        pr_addr = 32'h0000_8000;
        tick();
        com_bus_gnt = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_stall", 64'(cpu_stall), 64'(0));
        chk("t6_req", 64'(com_bus_req), 64'(0));
        chk("t6_addr", 64'(com_addr), 64'(0));
        chk("t6_avld", 64'(com_addr_vld), 64'(0));
        chk("t6_data", 64'(pr_data), 64'(0));
        chk("t6_blk", 64'(blk_accessed), 64'(0));
        pr_rd = 1'b0;
        com_bus_gnt = 1'b0;
        tick();
        rst = 1'b0;
        m_clear();
        tick();
        do_read(32'h0000_3000, 0, 0, 32'h3030_3030, 1'b0, 1'b0);

        // Randomized reads over a small address pool with snoops and grant drops.
        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 5) << (OFF_W + IDX_W)) | ($urandom_range(0, 2) << OFF_W)
                | $urandom_range(0, 3);
            if ($urandom_range(0, 5) == 0)
                do_idle_inv(($urandom_range(0, 5) << (OFF_W + IDX_W)) | ($urandom_range(0, 2) << OFF_W));
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
